// File: rtl/al422_fifo_writer.sv
// rtl/al422_fifo_writer.sv - AL422 frame FIFO write-port controller (WCK, /WE, /WRST, DI) fed by a valid/ready byte stream.
// Optional mid-frame abort on frame_start is enabled by defining AL422_FRAME_ABORT_EN.
module al422_fifo_writer #(
    parameter int FRAME_BYTES = 24,
    parameter int RST_CYCLES  = 4
) (
    input  logic       in_clk,
    input  logic       in_nrst,
    input  logic       frame_start,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [7:0] al422_data_out,
    output logic       al422_wck_out,
    output logic       al422_nwe_out,
    output logic       al422_nwrst_out,
    output logic       module_is_busy,
    output logic       frame_done
);

    localparam int CNT_W = $clog2(FRAME_BYTES + 1);
    localparam int RC_W  = $clog2(2 * RST_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES - 1);
    localparam logic [RC_W-1:0]  RST_LAST = RC_W'(2 * RST_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RESET,
        ST_WRITE,
        ST_FLUSH
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic [7:0]       data_q, data_d;
    logic             wck_q, wck_d;
    logic             nwe_q, nwe_d;
    logic             nwrst_q, nwrst_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // A byte is taken only on the cycle that ends with the WCK fall.
    assign in_ready = (state_q == ST_WRITE) && wck_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rst_cnt_d = rst_cnt_q;
        data_d    = data_q;
        wck_d     = wck_q;
        nwe_d     = nwe_q;
        nwrst_d   = nwrst_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d   = ST_RESET;
                    cnt_d     = '0;
                    rst_cnt_d = '0;
                    wck_d     = 1'b0;
                    nwe_d     = 1'b1;
                    nwrst_d   = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            ST_RESET: begin
                wck_d = ~wck_q;
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WRITE;
                    nwrst_d = 1'b1;
                    wck_d   = 1'b0;
                end else begin
                    rst_cnt_d = rst_cnt_q + 1'b1;
                end
            end
            ST_WRITE: begin
                wck_d = ~wck_q;
                if (wck_q) begin
                    if (in_valid) begin
                        data_d = in_data;
                        nwe_d  = 1'b0;
                        cnt_d  = cnt_q + 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = ST_FLUSH;
                        end
                    end else begin
                        nwe_d = 1'b1;
                    end
                end
            end
            ST_FLUSH: begin
                // First edge raises WCK to commit the last byte, second closes the frame.
                if (!wck_q) begin
                    wck_d = 1'b1;
                end else begin
                    wck_d   = 1'b0;
                    nwe_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef AL422_FRAME_ABORT_EN
        if (frame_start && (state_q != ST_IDLE)) begin
            state_d   = ST_RESET;
            cnt_d     = '0;
            rst_cnt_d = '0;
            wck_d     = 1'b0;
            nwe_d     = 1'b1;
            nwrst_d   = 1'b0;
            busy_d    = 1'b1;
            done_d    = 1'b0;
        end
`else
`endif
    end

    always_ff @(posedge in_clk or negedge in_nrst) begin
        if (!in_nrst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            rst_cnt_q <= '0;
            data_q    <= 8'h00;
            wck_q     <= 1'b0;
            nwe_q     <= 1'b1;
            nwrst_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rst_cnt_q <= rst_cnt_d;
            data_q    <= data_d;
            wck_q     <= wck_d;
            nwe_q     <= nwe_d;
            nwrst_q   <= nwrst_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign al422_data_out  = data_q;
    assign al422_wck_out   = wck_q;
    assign al422_nwe_out   = nwe_q;
    assign al422_nwrst_out = nwrst_q;
    assign module_is_busy  = busy_q;
    assign frame_done      = done_q;

endmodule
